// File: rtl/conv_line_packer.sv
// Packs raster RGB pixels into 240-bit words (10 px) and queues them for the engine.
// Optional macro PACKER_EDGE_REPLICATE_EN: pad row-end words with the last pixel.
module conv_line_packer #(
  parameter int width  = 1920,
  parameter int height = 1080,
  parameter int depth  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [23:0]  iPixel,
  input  logic         iValid,
  output logic         oReady,
  input  logic         iReq,
  output logic [239:0] oData,
  output logic         oValid,
  output logic         oDone
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam int RW = (height > 1) ? $clog2(height) : 1;
  localparam int AW = $clog2(depth);
  localparam int NW = AW + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(height - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(depth);

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [3:0]     slot_q, slot_d;
  logic [239:0]   pack_q, pack_d;
  logic           frame_last_q, frame_last_d;
  logic           started_q, started_d;
  logic [NW-1:0]  count_q, count_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [239:0]   mem_q [depth];
  logic [239:0]   mem_d [depth];
  logic           tag_q [depth];
  logic           tag_d [depth];
  logic [239:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;

  logic           xfer;
  logic           col_end;
  logic           row_end;
  logic           close;
  logic           frame_end;
  logic           pop;
  logic [23:0]    pad_px;
  logic [239:0]   word_c;

  assign oReady = started_q & (count_q < DEPTH_N) & ~frame_last_q;
  assign oData  = data_q;
  assign oValid = valid_q;
  assign oDone  = done_q;

  always_comb begin
    xfer      = iValid & oReady;
    col_end   = (col_q == COL_LAST);
    row_end   = (row_q == ROW_LAST);
    close     = xfer & ((slot_q == 4'd9) | col_end);
    frame_end = xfer & col_end & row_end;
    pop       = iReq & (count_q != '0);
  end

`ifdef PACKER_EDGE_REPLICATE_EN
  assign pad_px = iPixel;
`else
  assign pad_px = '0;
`endif

  // Word as it stands with the current pixel dropped into its slot.
  always_comb begin
    word_c = '0;
    for (int i = 0; i < 10; i++) begin
      if (4'(i) < slot_q) begin
        word_c[239-24*i -: 24] = pack_q[239-24*i -: 24];
      end else if (4'(i) == slot_q) begin
        word_c[239-24*i -: 24] = iPixel;
      end else begin
        word_c[239-24*i -: 24] = pad_px;
      end
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    slot_d       = slot_q;
    pack_d       = pack_q;
    frame_last_d = frame_last_q;
    started_d    = 1'b1;
    if (xfer) begin
      col_d  = col_end ? '0 : col_q + 1'b1;
      if (col_end) begin
        row_d = row_end ? '0 : row_q + 1'b1;
      end
      if (close) begin
        slot_d = '0;
        pack_d = '0;
      end else begin
        slot_d = slot_q + 4'd1;
        pack_d = word_c;
      end
    end
    // Hold input off until the frame's final word has been handed out.
    if (frame_end) begin
      frame_last_d = 1'b1;
    end else if (done_q) begin
      frame_last_d = 1'b0;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + NW'(close) - NW'(pop);
    if (close) begin
      mem_d[wr_ptr_q] = word_c;
      tag_d[wr_ptr_q] = frame_end;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    valid_d = pop;
    done_d  = pop & tag_q[rd_ptr_q];
    data_d  = pop ? mem_q[rd_ptr_q] : data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      slot_q       <= '0;
      pack_q       <= '0;
      frame_last_q <= 1'b0;
      started_q    <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      slot_q       <= slot_d;
      pack_q       <= pack_d;
      frame_last_q <= frame_last_d;
      started_q    <= started_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= mem_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_line_packer.sv
// Directed bench for conv_line_packer: 13x3 frames, 2-word FIFO.
// Covers packing, row-end padding, backpressure, empty requests, async reset.
module tb_conv_line_packer;

  logic         clk;
  logic         reset;
  logic [23:0]  iPixel;
  logic         iValid;
  logic         oReady;
  logic         iReq;
  logic [239:0] oData;
  logic         oValid;
  logic         oDone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [239:0] words [$];
  logic         dones [$];
  int           cycs  [$];

  conv_line_packer #(
    .width (13),
    .height(3),
    .depth (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .iPixel(iPixel),
    .iValid(iValid),
    .oReady(oReady),
    .iReq  (iReq),
    .oData (oData),
    .oValid(oValid),
    .oDone (oDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #2;
    if (oValid) begin
      words.push_back(oData);
      dones.push_back(oDone);
      cycs.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [239:0] obs,
                     input logic [239:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [239:0] ew(input int first, input int n);
    logic [239:0] w;
    logic [23:0]  pad;
    w = '0;
`ifdef PACKER_EDGE_REPLICATE_EN
    pad = 24'(first + n - 1);
`else
    pad = '0;
`endif
    for (int i = 0; i < 10; i++) begin
      w[239-24*i -: 24] = (i < n) ? 24'(first + i) : pad;
    end
    return w;
  endfunction

  task automatic send(input logic [23:0] p, output int xc);
    int n;
    n = 0;
    iPixel = p;
    iValid = 1'b1;
    while (!oReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout: oReady low for %0d cycles, required 1", n);
    end
    xc = cyc;
    @(posedge clk);
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic wait_words(input int target);
    int n;
    n = 0;
    while (words.size() < target && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    int f [6];
    int m [6];
    f = '{1, 11, 14, 24, 27, 37};
    m = '{10, 3, 10, 3, 10, 3};
    chk({tag, "_nwords"}, 240'(words.size() - base), 240'(6));
    for (int j = 0; j < 6; j++) begin
      if (base + j < words.size()) begin
        chk($sformatf("%s_word%0d", tag, j), words[base+j], ew(f[j], m[j]));
        chk($sformatf("%s_done%0d", tag, j), 240'(dones[base+j]),
            240'(j == 5));
      end
    end
  endtask

  initial begin
    int xc;
    int x10;
    int base;

    reset  = 1'b0;
    iValid = 1'b0;
    iReq   = 1'b0;
    iPixel = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_oReady", 240'(oReady), 240'(0));
    chk("rst_oValid", 240'(oValid), 240'(0));
    chk("rst_oDone", 240'(oDone), 240'(0));
    chk("rst_oData", oData, 240'(0));
    reset = 1'b1;
    #1;
    chk("rel_oReady_low", 240'(oReady), 240'(0));
    @(negedge clk);
    chk("rel_oReady_high", 240'(oReady), 240'(1));

    // Frame 1: streaming with iReq held high.
    iReq = 1'b1;
    base = words.size();
    x10 = 0;
    for (int i = 1; i <= 39; i++) begin
      send(24'(i), xc);
      if (i == 10) x10 = xc;
    end
    chk("f1_last_ready", 240'(oReady), 240'(0));
    chk("f1_last_done", 240'(oDone), 240'(0));
    @(negedge clk);
    chk("f1_done_pulse", 240'(oDone), 240'(1));
    chk("f1_done_ready", 240'(oReady), 240'(0));
    @(negedge clk);
    chk("f1_next_ready", 240'(oReady), 240'(1));
    chk("f1_done_cleared", 240'(oDone), 240'(0));
    wait_words(base + 6);
    check_frame("f1", base);
    if (words.size() > base) begin
      chk("f1_latency", 240'(cycs[base]), 240'(x10 + 2));
    end

    // Request while empty is dropped.
    iReq = 1'b0;
    base = words.size();
    @(negedge clk);
    iReq = 1'b1;
    @(negedge clk);
    iReq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("empty_req", 240'(words.size()), 240'(base));

    // Frame 2: backpressure with iReq low.
    for (int i = 1; i <= 13; i++) send(24'(i), xc);
    chk("bp_ready_low", 240'(oReady), 240'(0));
    chk("bp_no_output", 240'(words.size()), 240'(base));
    iReq = 1'b1;
    @(negedge clk);
    iReq = 1'b0;
    chk("bp_ready_back", 240'(oReady), 240'(1));
    iReq = 1'b1;
    for (int i = 14; i <= 39; i++) send(24'(i), xc);
    wait_words(base + 6);
    check_frame("f2", base);

    // Frame 3: word waits for a fresh request, then reset mid-row.
    iReq = 1'b0;
    repeat (3) @(negedge clk);
    base = words.size();
    for (int i = 1; i <= 10; i++) send(24'(i), xc);
    repeat (3) @(negedge clk);
    chk("f3_held", 240'(words.size()), 240'(base));
    iReq = 1'b1;
    @(negedge clk);
    iReq = 1'b0;
    chk("f3_one_word", 240'(words.size()), 240'(base + 1));
    if (words.size() > base) begin
      chk("f3_word", words[base], ew(1, 10));
    end
    @(negedge clk);
    chk("f3_valid_pulse", 240'(oValid), 240'(0));
    send(24'd11, xc);
    send(24'd12, xc);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_oData", oData, 240'(0));
    chk("arst_oValid", 240'(oValid), 240'(0));
    chk("arst_oDone", 240'(oDone), 240'(0));
    chk("arst_oReady", 240'(oReady), 240'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_rel_low", 240'(oReady), 240'(0));
    @(negedge clk);
    chk("arst_rel_high", 240'(oReady), 240'(1));

    // Frame 4: full frame after reset, no stale words.
    base = words.size();
    iReq = 1'b1;
    for (int i = 1; i <= 39; i++) send(24'(i), xc);
    wait_words(base + 6);
    repeat (3) @(negedge clk);
    check_frame("f4", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
